// File: rtl/stage3_fc_scheduler_pkg.sv
// Shared sizing, derived widths and FSM encoding for the stage-3 fully-connected scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stage3_fc_scheduler_pkg;

  localparam int CO      = 3;
  localparam int OF_BW   = 20;
  localparam int W_BW    = 8;
  localparam int N_POS   = 16;
  localparam int N_OUT   = 10;
  localparam int KOUT_BW = OF_BW + W_BW + $clog2(CO);
  localparam int ACC_BW  = KOUT_BW + $clog2(N_POS);
  localparam int WA_BW   = $clog2(N_OUT * N_POS);
  localparam int PA_BW   = (N_POS > 1) ? $clog2(N_POS) : 1;
  localparam int KA_BW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int RC_BW   = $clog2(N_OUT * N_POS + 1);

  typedef logic [CO*OF_BW-1:0] feat_vec_t;
  typedef logic [CO*W_BW-1:0]  wgt_vec_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } fc_state_t;

endpackage

// File: rtl/stage3_fc_feat_buf.sv
// Pooled-map buffer: DEPTH x WIDTH, one write port, one registered read port.
// Latency: read data valid one cycle after rd_en.
// Backpressure: none; writes and reads always complete.
module stage3_fc_feat_buf
  import stage3_fc_scheduler_pkg::*;
#(
  parameter int DEPTH = N_POS,
  parameter int WIDTH = CO * OF_BW,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/stage3_fc_scheduler.sv
// FC-layer sequencer around the dot-product kernel; optional argmax via STAGE3_FC_ARGMAX_EN.
// Latency: scores follow kernel results by one cycle; o_done one cycle after the last score.
// Backpressure: input accepted only in IDLE/LOAD; beats offered in RUN/FLUSH/DONE are dropped.
module stage3_fc_scheduler
  import stage3_fc_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [CO*OF_BW-1:0] i_in_data,
  output logic                o_w_en,
  output logic [WA_BW-1:0]    o_w_addr,
  input  logic [CO*W_BW-1:0]  i_w_data,
  output logic                o_k_valid,
  output logic [CO*OF_BW-1:0] o_k_pool,
  output logic [CO*W_BW-1:0]  o_k_weight,
  input  logic                i_k_valid,
  input  logic [KOUT_BW-1:0]  i_k_data,
  output logic                o_score_valid,
  output logic [ACC_BW-1:0]   o_score,
  output logic [KA_BW-1:0]    o_score_idx,
  output logic                o_done,
  output logic                o_busy
`ifdef STAGE3_FC_ARGMAX_EN
  ,
  output logic                o_class_valid,
  output logic [KA_BW-1:0]    o_class
`endif
);

  fc_state_t state, state_nxt;

  logic [PA_BW-1:0] wr_ptr, iss_p, rcv_p;
  logic [KA_BW-1:0] iss_k, rcv_k;
  logic [RC_BW-1:0] rcv_cnt;
  logic signed [ACC_BW-1:0] acc, k_ext, sum;

  logic in_acc, wr_last, iss_p_last, iss_last, rcv_en, rcv_last_p, rcv_all, score_evt;

  assign in_acc     = i_in_valid && o_in_ready;
  assign wr_last    = (wr_ptr == PA_BW'(N_POS - 1));
  assign iss_p_last = (iss_p == PA_BW'(N_POS - 1));
  assign iss_last   = iss_p_last && (iss_k == KA_BW'(N_OUT - 1));
  assign rcv_en     = i_k_valid && ((state == ST_RUN) || (state == ST_FLUSH));
  assign rcv_last_p = (rcv_p == PA_BW'(N_POS - 1));
  assign rcv_all    = (rcv_cnt == RC_BW'(N_OUT * N_POS));
  assign score_evt  = rcv_en && rcv_last_p;
  assign k_ext      = {{(ACC_BW-KOUT_BW){i_k_data[KOUT_BW-1]}}, i_k_data};
  assign sum        = acc + k_ext;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_acc) state_nxt = wr_last ? ST_RUN : ST_LOAD;
      ST_LOAD:  if (in_acc && wr_last) state_nxt = ST_RUN;
      ST_RUN:   if (iss_last) state_nxt = ST_FLUSH;
      ST_FLUSH: if (rcv_all) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready = (state == ST_IDLE) || (state == ST_LOAD);
    o_busy     = (state != ST_IDLE);
    o_done     = (state == ST_DONE);
    o_w_en     = (state == ST_RUN);
    o_w_addr   = '0;
    if (state == ST_RUN)
      o_w_addr = WA_BW'(iss_k) * WA_BW'(N_POS) + WA_BW'(iss_p);
  end

  // Write pointer wraps to 0 on the final beat, so IDLE always writes slot 0.
  always_ff @(posedge clk) begin
    if (reset)       wr_ptr <= '0;
    else if (in_acc) wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iss_p <= '0;
      iss_k <= '0;
    end else if (state == ST_RUN) begin
      iss_p <= iss_p_last ? '0 : iss_p + 1'b1;
      if (iss_p_last) iss_k <= iss_last ? '0 : iss_k + 1'b1;
    end
  end

  stage3_fc_feat_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (in_acc),
    .wr_addr (wr_ptr),
    .wr_data (i_in_data),
    .rd_en   (state == ST_RUN),
    .rd_addr (iss_p),
    .rd_data (o_k_pool)
  );

  always_ff @(posedge clk) begin
    if (reset) o_k_valid <= 1'b0;
    else       o_k_valid <= (state == ST_RUN);
  end

  assign o_k_weight = i_w_data;

  // Return side relies only on result order, never on kernel latency.
  always_ff @(posedge clk) begin
    if (reset || !((state == ST_RUN) || (state == ST_FLUSH))) begin
      acc     <= '0;
      rcv_p   <= '0;
      rcv_k   <= '0;
      rcv_cnt <= '0;
    end else if (rcv_en) begin
      acc     <= rcv_last_p ? '0 : sum;
      rcv_p   <= rcv_last_p ? '0 : rcv_p + 1'b1;
      rcv_cnt <= rcv_cnt + 1'b1;
      if (rcv_last_p) rcv_k <= rcv_k + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_score_valid <= 1'b0;
      o_score       <= '0;
      o_score_idx   <= '0;
    end else begin
      o_score_valid <= score_evt;
      if (score_evt) begin
        o_score     <= sum;
        o_score_idx <= rcv_k;
      end
    end
  end

`ifdef STAGE3_FC_ARGMAX_EN
  logic signed [ACC_BW-1:0] best_score;
  logic [KA_BW-1:0]         best_idx, cls_q;

  // Strict compare keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (reset) begin
      best_score <= '0;
      best_idx   <= '0;
    end else if (score_evt && ((rcv_k == '0) || (sum > best_score))) begin
      best_score <= sum;
      best_idx   <= rcv_k;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                           cls_q <= '0;
    else if ((state == ST_FLUSH) && (state_nxt == ST_DONE)) cls_q <= best_idx;
  end

  assign o_class_valid = (state == ST_DONE);
  assign o_class       = cls_q;
`endif

endmodule
